pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register that generalises the fixed-field stage latches, such as the execute/memory latch. It carries an opaque payload of `DATA_W` bits across a valid/ready handshake and supports an optional 2-entry skid buffer. It also provides flush, bubble (NOP) insertion with a configurable NOP pattern, an occupancy output, and a saturating counter of flushed instructions. It sits between any two pipeline stages and replaces ad-hoc stall-vector decoding with local backpressure.

## Interface
Parameters:
- `DATA_W`, default 64: payload width in bits (≥1).
- `SKID`, default 1:
  - 0: single register; `in_ready` is combinational from `out_ready`.
  - 1: two entries (main + skid); `in_ready` is registered.
- `NOP_VALUE`, default `{DATA_W{1'b0}}`: payload driven whenever the stage holds no valid entry.
- `CNT_W`, default 8: width of the flush-drop counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: discard all held entries this edge.
- `in_valid`, in, 1: upstream presents a payload.
- `in_ready`, out, 1: stage accepts the payload this cycle.
- `in_data`, in, `DATA_W`: upstream payload.
- `out_valid`, out, 1: stage presents a payload downstream.
- `out_ready`, in, 1: downstream accepts the payload this cycle.
- `out_data`, out, `DATA_W`: downstream payload; equals `NOP_VALUE` when `out_valid`=0.
- `level`, out, 2: entries held (0..2; max 1 when `SKID`=0).
- `drop_cnt`, out, `CNT_W`: saturating count of valid entries discarded by `flush`.

## Operation
- Definitions: `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- States:
  - EMPTY (level 0).
  - ONE (main valid, level 1).
  - TWO (main and skid valid, level 2; `SKID`=1 only).
- `in_ready`:
  - `SKID`=1: `in_ready` = (state != TWO), decoded from state flops only.
  - `SKID`=0: `in_ready` = !`out_valid` | `out_ready`.
- Transitions (no `rst`, no `flush`):
  - EMPTY: if `in_fire`, main <= `in_data`, go to ONE. Otherwise stay.
  - ONE, `in_fire` & `out_fire`: main <= `in_data`, stay in ONE.
  - ONE, `in_fire` & !`out_fire`:
    - `SKID`=1: skid <= `in_data`, go to TWO.
    - `SKID`=0: this case cannot occur.
  - ONE, !`in_fire` & `out_fire`: main <= `NOP_VALUE`, go to EMPTY.
  - ONE, neither fire: hold.
  - TWO, `out_fire`: main <= skid, skid <= `NOP_VALUE`, go to ONE.
  - TWO, no `out_fire`: hold; `in_ready`=0.
- Ordering: FIFO order is strict; the skid entry never overtakes main.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_data` must not change.
- `out_data` is driven directly from the main register, with no output mux. Main is written `NOP_VALUE` whenever it becomes empty.
- `flush` (priority below `rst`, above everything else):
  - Next state is EMPTY; main and skid <= `NOP_VALUE`.
  - An `in_fire` in the same cycle is discarded and is not counted.
  - An `out_fire` in the same cycle completes; that entry counts as consumed, not dropped.
  - `drop_cnt` += (level − `out_fire`), saturating at 2^`CNT_W`−1.
- `rst`:
  - State EMPTY; main and skid = `NOP_VALUE`.
  - `drop_cnt` = 0.
  - Reset mid-transfer discards all entries without counting them.
- Reset values: `out_valid`=0, `out_data`=`NOP_VALUE`, `level`=0, `drop_cnt`=0.
  - `in_ready`=1 when `SKID`=1.
  - `in_ready`=1 when `SKID`=0 (follows from `out_valid`=0).

## Timing
- Latency is 1 cycle: a payload accepted at edge N is visible on `out_data` and `out_valid` after edge N.
- Throughput is 1 payload per cycle in steady state, in both `SKID` modes.
- `SKID`=1: `in_ready` has no combinational path from `out_ready`, which breaks the ready timing path. One bubble-free stall of depth 1 is absorbed.
- `SKID`=0: `in_ready` depends combinationally on `out_ready`.
- `level` and `drop_cnt` are registered and update on the same edge as the state.
- `drop_cnt` holds at its maximum value; it never wraps.

## Test plan
- Streaming: `SKID`=1, `DATA_W`=32, `out_ready`=1, push 0x1..0x8 back-to-back. Required: 0x1..0x8 appear in order, one per cycle, 1-cycle latency; `level` stays at 1.
- Backpressure: `SKID`=1, hold `out_ready`=0 while pushing 0xA, 0xB, 0xC. Required:
  - `level` reaches 2 and `in_ready`=0 after 0xB.
  - 0xC is held upstream.
  - After `out_ready`=1, the order is 0xA, 0xB, 0xC with no loss.
- Flush with count: fill to level 2, then assert `flush` with `out_ready`=0 and `in_valid`=1 (0xD). Required:
  - Next cycle `level`=0, `out_valid`=0, `out_data`=`NOP_VALUE`.
  - `drop_cnt`=2; 0xD is not captured.
- Flush with simultaneous out_fire: level 1, `out_ready`=1, `flush`=1. Required: entry consumed, `drop_cnt` unchanged.
- Saturation and reset: `CNT_W`=2, perform 3 flushes at level 2. Required:
  - `drop_cnt`=3, held at 3.
  - After `rst`, all outputs take their reset values.
  - `NOP_VALUE`=0xDEAD appears on `out_data` when empty.
- `SKID`=0 variant: alternate `out_ready` 1/0 while `in_valid`=1. Required: `in_ready` equals `out_ready` whenever `out_valid`=1; `level` never exceeds 1.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Generic pipeline-stage register with a valid/ready handshake and an optional 2-entry skid buffer.
// Supports flush, a configurable NOP payload when empty, and a saturating count of flushed entries.
module pipe_skid_reg #(
  parameter int                 DATA_W    = 64,
  parameter int                 SKID      = 1,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int                 CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  drop_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   main_reg, main_next;
  logic [DATA_W-1:0]   skid_reg, skid_next;
  logic [CNT_W-1:0]    drop_reg, drop_next;
  logic [CNT_W+1:0]    drop_sum;
  logic                in_fire;
  logic                out_fire;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_reg != TWO);
    end else begin : g_noskid
      assign in_ready = (state_reg == EMPTY) | out_ready;
    end
  endgenerate

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign level     = state_reg;
  assign drop_cnt  = drop_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // out_fire implies level >= 1, so this never underflows.
  assign drop_sum = {2'b00, drop_reg} + {{CNT_W{1'b0}}, state_reg}
                  - {{(CNT_W+1){1'b0}}, out_fire};

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    drop_next  = drop_reg;

    unique case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          main_next  = in_data;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire && (SKID != 0)) begin
          skid_next  = in_data;
          state_next = TWO;
        end else if (out_fire) begin
          main_next  = NOP_VALUE;
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_next  = skid_reg;
          skid_next  = NOP_VALUE;
          state_next = ONE;
        end
      end
      default: begin
        main_next  = NOP_VALUE;
        skid_next  = NOP_VALUE;
        state_next = EMPTY;
      end
    endcase

    if (flush) begin
      state_next = EMPTY;
      main_next  = NOP_VALUE;
      skid_next  = NOP_VALUE;
      drop_next  = (drop_sum > {2'b00, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      main_reg  <= NOP_VALUE;
      skid_reg  <= NOP_VALUE;
      drop_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      drop_reg  <= drop_next;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench: skid instance (32-bit, 2-bit drop counter, NOP 0xDEAD) and a no-skid instance.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  level;
  logic [1:0]  drop_cnt;

  logic        flush0, in_valid0, out_ready0;
  logic [31:0] in_data0;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  level0;
  logic [7:0]  drop_cnt0;

  int n_vec = 0;
  int n_bad = 0;

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_in_fire, m_out_fire;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(32), .SKID(1), .NOP_VALUE(32'hDEAD), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .drop_cnt(drop_cnt)
  );

  pipe_skid_reg #(.DATA_W(32), .SKID(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .level(level0), .drop_cnt(drop_cnt0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one payload while downstream is stalled.
  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 32'hDEAD);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready0", in_ready0, 1);
    chk("rst_out_valid0", out_valid0, 0);

    // Streaming 1..8 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 64'(i));
      chk("stream_level", level, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_nop", out_data, 32'hDEAD);
    chk("stream_drain_level", level, 0);

    // Backpressure A, B, C
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    chk("bp_a_data", out_data, 32'hA);
    chk("bp_a_level", level, 1);
    chk("bp_b_in_ready", in_ready, 1);
    in_data = 32'hB;
    tick();
    chk("bp_b_level", level, 2);
    chk("bp_b_in_ready_low", in_ready, 0);
    chk("bp_b_data_stable", out_data, 32'hA);
    in_data = 32'hC;
    tick();
    chk("bp_c_held_level", level, 2);
    chk("bp_c_held_data", out_data, 32'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", out_data, 32'hB);
    chk("bp_out_b_level", level, 1);
    chk("bp_out_b_in_ready", in_ready, 1);
    tick();
    chk("bp_out_c", out_data, 32'hC);
    chk("bp_out_c_level", level, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty_level", level, 0);

    // Flush at level 2 with a concurrent upstream offer
    out_ready = 1'b0;
    push(32'h11);
    push(32'h22);
    chk("fl_fill_level", level, 2);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hD;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_data", out_data, 32'hDEAD);
    chk("fl_drop", drop_cnt, 2);
    tick();
    chk("fl_no_capture", out_valid, 0);

    // Flush with simultaneous out_fire: entry counts as consumed
    push(32'h33);
    chk("flo_level1", level, 1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flo_drop_same", drop_cnt, 2);
    chk("flo_level", level, 0);

    // Saturation of the 2-bit counter
    push(32'h44); push(32'h55);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("sat_drop_3", drop_cnt, 3);
    push(32'h66); push(32'h77);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("sat_drop_hold", drop_cnt, 3);
    push(32'h88); push(32'h99);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("sat_drop_hold2", drop_cnt, 3);

    // Reset mid-transfer
    push(32'hAA);
    chk("rst2_pre_level", level, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 32'hDEAD);
    chk("rst2_level", level, 0);
    chk("rst2_drop", drop_cnt, 0);
    chk("rst2_in_ready", in_ready, 1);

    // No-skid instance: alternating downstream ready, continuous upstream offer
    m_valid = 1'b0;
    m_data  = '0;
    for (int k = 0; k < 10; k++) begin
      in_valid0  = 1'b1;
      in_data0   = 32'h100 + 32'(k);
      out_ready0 = k[0];
      #1;
      if (out_valid0) chk("s0_in_ready_eq_out_ready", in_ready0, out_ready0);
      else            chk("s0_in_ready_empty", in_ready0, 1);
      m_out_fire = m_valid & out_ready0;
      m_in_fire  = !m_valid | out_ready0;
      tick();
      if (m_in_fire) begin
        m_valid = 1'b1;
        m_data  = in_data0;
      end else if (m_out_fire) begin
        m_valid = 1'b0;
      end
      chk("s0_out_valid", out_valid0, m_valid);
      chk("s0_out_data", out_data0, m_valid ? m_data : 32'h0);
      chk("s0_level_max1", level0 <= 2'd1, 1);
    end
    in_valid0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
